// File: rtl/ca_line_engine.sv
// ca_line_engine
//
// Draws a 1-D, 3-neighbour cellular automaton, one generation per scan line.
// The current generation lives in a WIDTH x 1 line RAM. While a line is
// scanned out, each cell is shown and its successor is written back into the
// same RAM location, so the RAM holds the next generation once the line ends.
// Every frame starts again from a single live cell at SEED_POS. The rule is
// latched only when reseeding starts, so changing it mid-frame has no effect
// until the next frame.
//
// Ports
//   clk              pixel clock
//   rst              synchronous, active-high reset
//   rule             Wolfram rule number, latched when reseeding starts
//   inPrefetchArea   high while prefetchCounterX walks 0..WIDTH-1 on a visible line
//   prefetchCounterX cell index from the sync generator
//   counterY         line number from the sync generator
//   pixel_on         registered cell value, two cycles after its prefetch index
//   busy             registered (state != RUN)
module ca_line_engine #(
    parameter int         WIDTH     = 1280,
    parameter int         SEED_LINE = 1024,
    parameter int         LAST_LINE = 1065,
    parameter int         SEED_POS  = 640,
    parameter logic [7:0] RULE      = 8'd30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rule,
    input  logic        inPrefetchArea,
    input  logic [10:0] prefetchCounterX,
    input  logic [10:0] counterY,
    output logic        pixel_on,
    output logic        busy
);

    localparam logic [10:0] LAST_X = 11'(WIDTH - 1);
    localparam logic [10:0] SEED_X = 11'(SEED_POS);
    localparam logic [10:0] SEED_Y = 11'(SEED_LINE);
    localparam logic [10:0] LAST_Y = 11'(LAST_LINE);

    typedef enum logic [1:0] {
        ST_SEED = 2'd0,
        ST_WAIT = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [10:0] s_reg;
    logic [7:0]  rule_reg;

    // Pipeline registers
    logic        v1_reg;
    logic        last1_reg;
    logic [10:0] x1_reg;
    logic        l_reg;
    logic        c_reg;
    logic        rd_data_reg;

    // Line RAM
    logic        mem [0:WIDTH-1];
    logic [10:0] rd_addr;
    logic        we;
    logic [10:0] wa;
    logic        wd;
    logic        r;

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_SEED: if (s_reg == LAST_X)    state_next = ST_WAIT;
            ST_WAIT: if (counterY == LAST_Y) state_next = ST_RUN;
            ST_RUN:  if (counterY == SEED_Y) state_next = ST_SEED;
            default: state_next = ST_SEED;
        endcase
    end

    // Right neighbour: beyond the last cell is always dead (no wrap-around).
    assign r = last1_reg ? 1'b0 : rd_data_reg;

    // Stage 0 fetches one cell ahead; outside the visible run it parks on
    // address 0 so the blank cycles preload the first cell of the next line.
    always_comb begin
        rd_addr = '0;
        if (inPrefetchArea && (prefetchCounterX != LAST_X)) begin
            rd_addr = prefetchCounterX + 11'd1;
        end
    end

    // The single write port is owned by the seeder in SEED and by the
    // compute stage in RUN; the two never overlap.
    always_comb begin
        we = 1'b0;
        wa = s_reg;
        wd = (s_reg == SEED_X);
        if (state_reg == ST_SEED) begin
            we = 1'b1;
        end else if ((state_reg == ST_RUN) && v1_reg) begin
            we = 1'b1;
            wa = x1_reg;
            wd = rule_reg[{l_reg, c_reg, r}];
        end
    end

    // In-place update is safe: cell x is written one cycle after x+1 was
    // read, and its old value survives in l_reg for cell x+1's computation.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wa] <= wd;
        end
        rd_data_reg <= mem[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_SEED;
            s_reg     <= '0;
            rule_reg  <= RULE;
            v1_reg    <= 1'b0;
            last1_reg <= 1'b0;
            x1_reg    <= '0;
            l_reg     <= 1'b0;
            c_reg     <= 1'b0;
            pixel_on  <= 1'b0;
            busy      <= 1'b1;
        end else begin
            state_reg <= state_next;
            busy      <= (state_reg != ST_RUN);

            if ((state_reg == ST_SEED) && (s_reg != LAST_X)) begin
                s_reg <= s_reg + 11'd1;
            end
            if ((state_reg == ST_RUN) && (state_next == ST_SEED)) begin
                s_reg    <= '0;
                rule_reg <= rule;
            end

            // Stage 0
            v1_reg    <= inPrefetchArea;
            last1_reg <= inPrefetchArea && (prefetchCounterX == LAST_X);
            x1_reg    <= prefetchCounterX;

            // Stage 1
            if (v1_reg) begin
                if (state_reg == ST_RUN) begin
                    pixel_on <= c_reg;
                    l_reg    <= c_reg;
                    c_reg    <= r;
                end else begin
                    pixel_on <= 1'b0;
                end
            end else begin
                // Between lines: left of cell 0 is dead, centre is new cell 0.
                l_reg    <= 1'b0;
                c_reg    <= rd_data_reg;
                pixel_on <= 1'b0;
            end
        end
    end

endmodule
